// File: rtl/aad_tile_loader.sv
// aad_tile_loader: packs a raster pixel stream into 8x8 tiles held on a valid/ready bus.
// Define AAD_LOADER_PINGPONG_EN for two-bank ping-pong build; default is a single bank.
module aad_tile_loader #(
    parameter int DATA_W   = 8,
    parameter int TILE_DIM = 8,
    parameter int CNT_W    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [DATA_W-1:0]                   in_pixel,
    input  logic                                in_last,
    output logic                                tile_valid,
    input  logic                                tile_ready,
    output logic [DATA_W*TILE_DIM*TILE_DIM-1:0] tile_data,
    output logic [CNT_W-1:0]                    tile_count,
    output logic                                err_last
);
    localparam int N     = TILE_DIM * TILE_DIM;
    localparam int IDX_W = $clog2(N);
`ifdef AAD_LOADER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_state_t;

    bank_state_t       r_state     [NB];
    bank_state_t       w_state_nxt [NB];
    logic [DATA_W-1:0] r_mem       [NB][N];
    logic [IDX_W-1:0]  r_wr_idx;
    logic              r_run;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic              w_wr_bank;
    logic              w_rd_bank;
    logic              w_accept;
    logic              w_consume;
    logic              w_last_beat;

    assign w_last_beat = r_wr_idx == IDX_W'(N - 1);
    assign in_ready    = r_run && r_state[w_wr_bank] != FULL;
    assign tile_valid  = r_state[w_rd_bank] == FULL;
    assign w_accept    = in_valid && in_ready;
    assign w_consume   = tile_valid && tile_ready;
    assign tile_count  = r_count;
    assign err_last    = r_err;

`ifdef AAD_LOADER_PINGPONG_EN
    logic r_wr_bank;
    logic r_rd_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_accept && w_last_beat) r_wr_bank <= ~r_wr_bank;
            if (w_consume) r_rd_bank <= ~r_rd_bank;
        end
    end

    assign w_wr_bank = r_wr_bank;
    assign w_rd_bank = r_rd_bank;
`else
    assign w_wr_bank = 1'b0;
    assign w_rd_bank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) r_state[b] <= EMPTY;
        end else begin
            for (int b = 0; b < NB; b++) r_state[b] <= w_state_nxt[b];
        end
    end

    // Consume and fill never target the same bank in one cycle: a FULL bank refuses beats.
    always_comb begin
        for (int b = 0; b < NB; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_consume && w_rd_bank == 1'(b)) w_state_nxt[b] = EMPTY;
            if (w_accept && w_wr_bank == 1'(b)) w_state_nxt[b] = w_last_beat ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < N; i++) r_mem[b][i] <= '0;
            r_wr_idx <= '0;
            r_run    <= 1'b0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_accept) begin
                r_mem[w_wr_bank][r_wr_idx] <= in_pixel;
                r_wr_idx <= r_wr_idx + 1'b1;
                if (in_last != w_last_beat) r_err <= 1'b1;
            end
            if (w_consume) r_count <= r_count + 1'b1;
        end
    end

    // Gating with tile_valid keeps the bus quiet while a bank is still being filled.
    for (genvar i = 0; i < N; i++) begin : g_out
        assign tile_data[i*DATA_W +: DATA_W] = tile_valid ? r_mem[w_rd_bank][i] : '0;
    end
endmodule

// File: tb/tb_aad_tile_loader.sv
// tb_aad_tile_loader: scoreboard bench for aad_tile_loader; tiles built from accepted beats
// are queued and compared by a monitor whenever a tile is presented.
module tb_aad_tile_loader;
`ifdef AAD_LOADER_PINGPONG_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         tile_ready = 1'b0;
    logic [7:0]   in_pixel = 8'h00;
    logic         in_ready;
    logic         tile_valid;
    logic         err_last;
    logic [511:0] tile_data;
    logic [15:0]  tile_count;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [511:0] exp_q[$];
    logic [511:0] cur_t = '0;
    int           cur_n = 0;
    int           n_cons = 0;
    logic         alive = 1'b0;
    logic         exp_err = 1'b0;
    logic         exp_ready = 1'b0;
    logic         rnd = 1'b0;

    aad_tile_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_last(in_last), .tile_valid(tile_valid),
        .tile_ready(tile_ready), .tile_data(tile_data), .tile_count(tile_count),
        .err_last(err_last)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endfunction

    // Reference model: every 64 accepted beats form one tile, row-major, byte k = beat k.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alive   <= 1'b0;
            cur_n   <= 0;
            exp_err <= 1'b0;
            exp_q.delete();
        end else begin
            alive <= 1'b1;
            if (in_valid && exp_ready) begin
                if (in_last != (cur_n == 63)) exp_err <= 1'b1;
                if (cur_n == 63) begin
                    exp_q.push_back({in_pixel, cur_t[503:0]});
                    cur_n <= 0;
                end else begin
                    cur_t[cur_n*8 +: 8] <= in_pixel;
                    cur_n <= cur_n + 1;
                end
            end
        end
    end

    // Monitor: one pending tile in the queue means tile_valid; room for another means in_ready.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", 512'(in_ready), 512'(0));
            chk("rst_tile_valid", 512'(tile_valid), 512'(0));
            chk("rst_tile_data", tile_data, 512'(0));
            chk("rst_tile_count", 512'(tile_count), 512'(0));
            chk("rst_err_last", 512'(err_last), 512'(0));
            n_cons    <= 0;
            exp_ready <= 1'b0;
        end else begin
            chk("in_ready", 512'(in_ready), 512'(alive && exp_q.size() < CAP));
            exp_ready <= alive && exp_q.size() < CAP;
            chk("tile_valid", 512'(tile_valid), 512'(exp_q.size() > 0));
            chk("tile_count", 512'(tile_count), 512'(16'(n_cons)));
            chk("err_last", 512'(err_last), 512'(exp_err));
            if (exp_q.size() > 0) begin
                chk("tile_data", tile_data, exp_q[0]);
                if (tile_ready) begin
                    void'(exp_q.pop_front());
                    n_cons <= n_cons + 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] px, input logic lst);
        int t;
        if (rnd && $urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pixel = px;
        in_last  = lst;
        t = 0;
        forever begin
            if (rnd) tile_ready = 1'($urandom_range(1));
            @(posedge clk);
            if (exp_ready) break;
            t++;
            if (t > 1000) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_timeout: got no accept want accept within 1000 cycles");
                break;
            end
            #1;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // kind 0: pixel = index, 1: constant val, 2: random; in_last on beat lastpos.
    task automatic send_tile(input int kind, input logic [7:0] val, input int lastpos,
                             input logic rdy63, input int nb);
        logic [7:0] px;
        for (int i = 0; i < nb; i++) begin
            px = kind == 0 ? 8'(i) : kind == 1 ? val : 8'($urandom);
            if (i == 63 && rdy63) tile_ready = 1'b1;
            send_beat(px, i == lastpos);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_in_ready", 512'(in_ready), 512'(0));
        chk("async_tile_valid", 512'(tile_valid), 512'(0));
        chk("async_tile_data", tile_data, 512'(0));
        chk("async_tile_count", 512'(tile_count), 512'(0));
        chk("async_err_last", 512'(err_last), 512'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tile_ready = 1'b1;
        send_tile(0, 8'h00, 63, 1'b0, 64);
        idle(5);
        tile_ready = 1'b0;
        send_tile(2, 8'h00, 63, 1'b0, 64);
        idle(100);
`ifdef AAD_LOADER_PINGPONG_EN
        send_tile(2, 8'h00, 63, 1'b0, 64);
`endif
        in_valid = 1'b1;
        in_pixel = 8'h5A;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        tile_ready = 1'b1;
        idle(5);
        send_tile(1, 8'h10, 63, 1'b0, 64);
        send_tile(1, 8'h20, 63, 1'b0, 64);
        send_tile(1, 8'h30, 63, 1'b0, 64);
        idle(5);
`ifdef AAD_LOADER_PINGPONG_EN
        tile_ready = 1'b0;
        send_tile(2, 8'h00, 63, 1'b0, 64);
        send_tile(2, 8'h00, 63, 1'b1, 64);
        idle(5);
`endif
        send_tile(2, 8'h00, 40, 1'b0, 64);
        idle(3);
        send_tile(2, 8'h00, 63, 1'b0, 64);
        idle(3);
        send_tile(2, 8'h00, 63, 1'b0, 30);
        do_reset();
        send_tile(1, 8'hFF, 63, 1'b0, 64);
        idle(3);
        rnd = 1'b1;
        for (int k = 0; k < 12; k++)
            send_tile(2, 8'h00, $urandom_range(9) == 0 ? 20 : 63, 1'b0, 64);
        rnd = 1'b0;
        tile_ready = 1'b1;
        for (int t = 0; t < 500 && exp_q.size() > 0; t++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d tiles pending want 0", exp_q.size());
        end
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
